// File: rtl/if_stage_fetch_if.sv
// Instruction-memory bus between the fetch stage and the asynchronous ROM.
// The master drives the word address and the ROM returns data in the same cycle.
interface if_stage_fetch_if #(
  parameter int ADDR_W = 8,
  parameter int INST_W = 16
) ();
  logic [ADDR_W-1:0] imem_addr;
  logic [INST_W-1:0] imem_rdata;

  modport master (output imem_addr, input imem_rdata);
  modport slave  (input imem_addr, output imem_rdata);
endinterface

// File: rtl/if_stage_fetch.sv
// Instruction-fetch stage with IF/ID pipeline register for the 16-bit 5-stage datapath.
// Handles load-use stalls, taken-branch redirects with a flush bubble, and halt-opcode freeze.
module if_stage_fetch #(
  parameter int                 ADDR_W   = 8,
  parameter int                 INST_W   = 16,
  parameter logic [3:0]         HALT_OP  = 4'hF,
  parameter logic [INST_W-1:0]  NOP_INST = 16'h0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [ADDR_W-1:0]     branch_target,
  if_stage_fetch_if.master      imem,
  output logic [ADDR_W-1:0]     PCOUT,
  output logic [INST_W-1:0]     INST,
  output logic                  inst_valid,
  output logic                  halted,
  output logic [15:0]           fetch_count
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pcout_q, pcout_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              valid_q, valid_d;
  logic [15:0]       count_q, count_d;
  logic              is_halt_op_s;

  // ROM address comes straight from the pc flop so stall/branch never reach it combinationally.
  assign imem.imem_addr = pc_q;
  assign is_halt_op_s   = (imem.imem_rdata[INST_W-1:INST_W-4] == HALT_OP);

  // Next-state: branch redirect beats stall, stall beats normal fetch or halt bubbles.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pcout_d = pcout_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    count_d = count_q;
    if (branch_taken) begin
      pc_d    = branch_target;
      pcout_d = pc_q;
      inst_d  = NOP_INST;
      valid_d = 1'b0;
      state_d = ST_RUN;
    end else if (stall) begin
      state_d = state_q;
    end else begin
      case (state_q)
        ST_RUN: begin
          pcout_d = pc_q;
          inst_d  = imem.imem_rdata;
          valid_d = 1'b1;
          count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
          if (is_halt_op_s) begin
            pc_d    = pc_q;
            state_d = ST_HALT;
          end else begin
            pc_d    = pc_q + ADDR_W'(1);
            state_d = ST_RUN;
          end
        end
        ST_HALT: begin
          pcout_d = pc_q;
          inst_d  = NOP_INST;
          valid_d = 1'b0;
        end
        default: begin
          state_d = ST_RUN;
          inst_d  = NOP_INST;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and IF/ID register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      pc_q    <= '0;
      pcout_q <= '0;
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
      count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pcout_q <= pcout_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign PCOUT       = pcout_q;
  assign INST        = inst_q;
  assign inst_valid  = valid_q;
  assign halted      = (state_q == ST_HALT);
  assign fetch_count = count_q;

endmodule
